// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C transaction arbiter: one-hot FSM state
// constants, transaction field widths and an index-width helper.
package i2c_arb_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;

    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_ARB    = 5'b00010;
    localparam logic [4:0] ST_LAUNCH = 5'b00100;
    localparam logic [4:0] ST_WAIT   = 5'b01000;
    localparam logic [4:0] ST_GAP    = 5'b10000;

    // Ceiling log2; bits needed to index 'value' distinct items.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin selector: starting at ptr_i and wrapping,
// returns the first asserted request as one-hot and as an index.
module i2c_rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan NREQ positions from the pointer upward; the first hit wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master engine between NREQ requesters. Round-robin grant,
// latched transaction fields, one-cycle start strobe, completion hand-back
// and an enforced bus-free gap. Optional watchdog in WAIT is enabled by
// defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned GAP_CYC     = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ-1:0]          REQ_RNW,
    input  logic [NREQ-1:0]          REQ_TWOBYTE,
    input  logic [ADDR_W*NREQ-1:0]   REQ_ADDR,
    input  logic [DATA_W*NREQ-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]          GNT,
    output logic [NREQ-1:0]          DONE,
    output logic [DATA_W-1:0]        RDATA,
    output logic                     ERR,
    output logic                     BUSY,
    output logic                     M_START_STB,
    output logic                     M_RNW,
    output logic                     M_TWOBYTE,
    output logic [ADDR_W-1:0]        M_I2C_ADDR,
    output logic [DATA_W-1:0]        M_WR_DATA,
    input  logic                     M_DONE,
    input  logic                     M_NACK,
    input  logic [DATA_W-1:0]        M_RD_DATA
);

    localparam int unsigned IDX_W   = clog2(NREQ);
    // One counter serves both the GAP count and the WAIT watchdog, so it is
    // sized for the larger of the two limits.
    localparam int unsigned CNT_MAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);

    logic [4:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  owner_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              stb_q;
    logic              m_rnw_q;
    logic              m_twobyte_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;

    logic [NREQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [IDX_W-1:0]  next_ptr;

    logic              arb_win;
    logic              fin;
    logic              tmo;

    logic              sel_rnw;
    logic              sel_twobyte;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    i2c_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (REQ),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    assign next_ptr = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);

    // AND-OR mux of the winner's transaction fields using the one-hot pick.
    always_comb begin
        sel_rnw     = 1'b0;
        sel_twobyte = 1'b0;
        sel_addr    = '0;
        sel_wdata   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sel_rnw     = sel_rnw     | (pick_onehot[i] & REQ_RNW[i]);
            sel_twobyte = sel_twobyte | (pick_onehot[i] & REQ_TWOBYTE[i]);
            sel_addr    = sel_addr    | ({ADDR_W{pick_onehot[i]}} & REQ_ADDR[i*ADDR_W +: ADDR_W]);
            sel_wdata   = sel_wdata   | ({DATA_W{pick_onehot[i]}} & REQ_WDATA[i*DATA_W +: DATA_W]);
        end
    end

    // Next-state, shared counter and transaction event decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arb_win = 1'b0;
        fin     = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|REQ) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (pick_valid) begin
                    arb_win = 1'b1;
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef I2C_ARB_TIMEOUT_EN
                if (M_DONE) begin
                    fin     = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    tmo     = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                if (M_DONE) begin
                    fin     = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
`endif
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched master fields and requester-facing status registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            stb_q       <= 1'b0;
            m_rnw_q     <= 1'b0;
            m_twobyte_q <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stb_q   <= arb_win;
            done_q  <= '0;
            if (arb_win) begin
                owner_q     <= pick_idx;
                gnt_q       <= pick_onehot;
                m_rnw_q     <= sel_rnw;
                m_twobyte_q <= sel_twobyte;
                m_addr_q    <= sel_addr;
                m_wdata_q   <= sel_wdata;
            end
            // M_DONE has priority over the watchdog: tmo is only raised when fin is low.
            if (fin || tmo) begin
                done_q <= gnt_q;
                err_q  <= fin ? M_NACK : 1'b1;
                ptr_q  <= next_ptr;
                gnt_q  <= '0;
            end
            if (fin && m_rnw_q) begin
                rdata_q <= M_RD_DATA;
            end
        end
    end

    assign GNT         = gnt_q;
    assign DONE        = done_q;
    assign RDATA       = rdata_q;
    assign ERR         = err_q;
    assign BUSY        = (state_q != ST_IDLE);
    assign M_START_STB = stb_q;
    assign M_RNW       = m_rnw_q;
    assign M_TWOBYTE   = m_twobyte_q;
    assign M_I2C_ADDR  = m_addr_q;
    assign M_WR_DATA   = m_wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: table-driven single transactions
// plus hand-written round-robin, mid-operation, reset and watchdog sequences.
module tb_i2c_txn_arbiter;

    localparam int unsigned NREQ        = 4;
    localparam int unsigned GAP_CYC     = 4;
    localparam int unsigned TIMEOUT_CYC = 64;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  REQ;
    logic [3:0]  REQ_RNW;
    logic [3:0]  REQ_TWOBYTE;
    logic [27:0] REQ_ADDR;
    logic [63:0] REQ_WDATA;
    logic [3:0]  GNT;
    logic [3:0]  DONE;
    logic [15:0] RDATA;
    logic        ERR;
    logic        BUSY;
    logic        M_START_STB;
    logic        M_RNW;
    logic        M_TWOBYTE;
    logic [6:0]  M_I2C_ADDR;
    logic [15:0] M_WR_DATA;
    logic        M_DONE;
    logic        M_NACK;
    logic [15:0] M_RD_DATA;

    always #5 CLK = ~CLK;

    i2c_txn_arbiter #(
        .NREQ        (NREQ),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ         (REQ),
        .REQ_RNW     (REQ_RNW),
        .REQ_TWOBYTE (REQ_TWOBYTE),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .GNT         (GNT),
        .DONE        (DONE),
        .RDATA       (RDATA),
        .ERR         (ERR),
        .BUSY        (BUSY),
        .M_START_STB (M_START_STB),
        .M_RNW       (M_RNW),
        .M_TWOBYTE   (M_TWOBYTE),
        .M_I2C_ADDR  (M_I2C_ADDR),
        .M_WR_DATA   (M_WR_DATA),
        .M_DONE      (M_DONE),
        .M_NACK      (M_NACK),
        .M_RD_DATA   (M_RD_DATA)
    );

    typedef struct {
        int unsigned idx;
        logic [3:0]  req;
        logic        rnw;
        logic        twobyte;
        logic [6:0]  addr;
        logic [15:0] wdata;
        logic        nack;
        logic [15:0] rd_in;
        logic [3:0]  exp_gnt;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_stb(input int budget, output int n);
        n = 0;
        while (M_START_STB !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("stb_seen", 32'(M_START_STB), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(BUSY), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        wait_idle();
        REQ_RNW     = (REQ_RNW & ~(4'b1 << v.idx)) | (4'(v.rnw) << v.idx);
        REQ_TWOBYTE = (REQ_TWOBYTE & ~(4'b1 << v.idx)) | (4'(v.twobyte) << v.idx);
        REQ_ADDR    = (REQ_ADDR & ~(28'h7F << (7 * v.idx))) | (28'(v.addr) << (7 * v.idx));
        REQ_WDATA   = (REQ_WDATA & ~(64'hFFFF << (16 * v.idx))) | (64'(v.wdata) << (16 * v.idx));
        REQ         = v.req;
        wait_stb(20, n);
        chk("launch_latency", 32'(n), 32'd2);
        chk("m_addr", 32'(M_I2C_ADDR), 32'(v.addr));
        chk("m_wdata", 32'(M_WR_DATA), 32'(v.wdata));
        chk("m_rnw", 32'(M_RNW), 32'(v.rnw));
        chk("m_twobyte", 32'(M_TWOBYTE), 32'(v.twobyte));
        chk("gnt_launch", 32'(GNT), 32'(v.exp_gnt));
        tick();
        chk("stb_one_cycle", 32'(M_START_STB), 32'd0);
        repeat (3) tick();
        M_DONE    = 1'b1;
        M_NACK    = v.nack;
        M_RD_DATA = v.rd_in;
        tick();
        M_DONE    = 1'b0;
        M_NACK    = 1'b0;
        M_RD_DATA = 16'hDEAD;
        chk("done_pulse", 32'(DONE), 32'(v.exp_gnt));
        chk("err", 32'(ERR), 32'(v.exp_err));
        chk("rdata", 32'(RDATA), 32'(v.exp_rdata));
        chk("gnt_cleared", 32'(GNT), 32'd0);
        REQ = '0;
        tick();
        chk("done_one_cycle", 32'(DONE), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        int         n;
        logic [3:0] order [5];

        vecs[0] = '{0, 4'b0001, 1'b0, 1'b1, 7'h50, 16'hA5C3, 1'b0, 16'h1234, 4'b0001, 1'b0, 16'h0000};
        vecs[1] = '{2, 4'b0100, 1'b1, 1'b1, 7'h21, 16'h0000, 1'b0, 16'hBEEF, 4'b0100, 1'b0, 16'hBEEF};
        vecs[2] = '{1, 4'b0010, 1'b0, 1'b0, 7'h3A, 16'h00FF, 1'b0, 16'h5555, 4'b0010, 1'b0, 16'hBEEF};
        vecs[3] = '{3, 4'b1000, 1'b0, 1'b1, 7'h7F, 16'hFFFF, 1'b1, 16'hAAAA, 4'b1000, 1'b1, 16'hBEEF};
        vecs[4] = '{3, 4'b1000, 1'b1, 1'b0, 7'h08, 16'h1357, 1'b0, 16'h0001, 4'b1000, 1'b0, 16'h0001};
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b0100;
        order[3] = 4'b1000;
        order[4] = 4'b0001;

        RESET       = 1'b1;
        REQ         = '0;
        REQ_RNW     = '0;
        REQ_TWOBYTE = '0;
        REQ_ADDR    = {7'h44, 7'h33, 7'h22, 7'h11};
        REQ_WDATA   = 64'h4444_3333_2222_1111;
        M_DONE      = 1'b0;
        M_NACK      = 1'b0;
        M_RD_DATA   = 16'hDEAD;
        tick();
        tick();
        chk("rst_gnt", 32'(GNT), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_rdata", 32'(RDATA), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_stb", 32'(M_START_STB), 32'd0);
        chk("rst_m_addr", 32'(M_I2C_ADDR), 32'd0);
        RESET = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Round-robin with all requesters held; pointer is 0 after owner 3.
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_stb(60, n);
            if (k > 0) chk("rr_gap", 32'(n), 32'(GAP_CYC + 2));
            chk("rr_gnt", 32'(GNT), 32'(order[k]));
            repeat (19) tick();
            M_DONE = 1'b1;
            tick();
            M_DONE = 1'b0;
            chk("rr_done", 32'(DONE), 32'(order[k]));
            if (k == 4) REQ = '0;
        end

        // Owner drops REQ and others change their inputs while in WAIT.
        wait_idle();
        REQ = 4'b0010;
        wait_stb(20, n);
        chk("mid_gnt", 32'(GNT), 32'h2);
        chk("mid_addr_launch", 32'(M_I2C_ADDR), 32'h3A);
        tick();
        REQ       = 4'b1100;
        REQ_ADDR  = '0;
        REQ_WDATA = '1;
        repeat (3) tick();
        chk("mid_addr_held", 32'(M_I2C_ADDR), 32'h3A);
        chk("mid_wdata_held", 32'(M_WR_DATA), 32'h00FF);
        chk("mid_gnt_held", 32'(GNT), 32'h2);
        REQ = '0;
        tick();
        M_DONE = 1'b1;
        tick();
        M_DONE = 1'b0;
        chk("mid_done", 32'(DONE), 32'h2);
        chk("mid_err", 32'(ERR), 32'd0);
        M_DONE = 1'b1;
        M_NACK = 1'b1;
        tick();
        M_DONE = 1'b0;
        M_NACK = 1'b0;
        chk("mdone_in_gap", 32'(DONE), 32'd0);
        chk("mdone_in_gap_err", 32'(ERR), 32'd0);
        wait_idle();
        M_DONE = 1'b1;
        M_NACK = 1'b1;
        tick();
        M_DONE = 1'b0;
        M_NACK = 1'b0;
        chk("mdone_in_idle", 32'(DONE), 32'd0);
        chk("mdone_in_idle_err", 32'(ERR), 32'd0);
        chk("mdone_in_idle_busy", 32'(BUSY), 32'd0);

        // Reset during WAIT: everything clears, pointer returns to 0.
        REQ = 4'b0100;
        wait_stb(20, n);
        chk("rstw_gnt", 32'(GNT), 32'h4);
        tick();
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        REQ   = '0;
        chk("rstw_gnt0", 32'(GNT), 32'd0);
        chk("rstw_done0", 32'(DONE), 32'd0);
        chk("rstw_rdata0", 32'(RDATA), 32'd0);
        chk("rstw_busy0", 32'(BUSY), 32'd0);
        chk("rstw_rnw0", 32'(M_RNW), 32'd0);
        chk("rstw_tb0", 32'(M_TWOBYTE), 32'd0);
        chk("rstw_wdata0", 32'(M_WR_DATA), 32'd0);
        M_DONE = 1'b1;
        tick();
        M_DONE = 1'b0;
        chk("rstw_no_done", 32'(DONE), 32'd0);
        REQ_ADDR = 28'h000000C;
        REQ      = 4'b1001;
        wait_stb(20, n);
        chk("rstw_latency", 32'(n), 32'd2);
        chk("rstw_ptr0_gnt", 32'(GNT), 32'h1);
        chk("rstw_addr", 32'(M_I2C_ADDR), 32'h0C);
        tick();
        tick();
        M_DONE = 1'b1;
        tick();
        M_DONE = 1'b0;
        REQ    = '0;
        chk("rstw_done", 32'(DONE), 32'h1);

`ifdef I2C_ARB_TIMEOUT_EN
        // Watchdog expiry: DONE with ERR=1 after 64 WAIT cycles.
        wait_idle();
        REQ = 4'b0010;
        wait_stb(20, n);
        repeat (64) tick();
        chk("tmo_not_early", 32'(DONE), 32'd0);
        tick();
        REQ = '0;
        chk("tmo_done", 32'(DONE), 32'h2);
        chk("tmo_err", 32'(ERR), 32'd1);
        chk("tmo_rdata", 32'(RDATA), 32'd0);
        // M_DONE on the expiry cycle takes the normal path (requester 2 reads).
        wait_idle();
        REQ = 4'b0100;
        wait_stb(20, n);
        repeat (64) tick();
        M_DONE    = 1'b1;
        M_NACK    = 1'b0;
        M_RD_DATA = 16'h4321;
        tick();
        M_DONE    = 1'b0;
        M_RD_DATA = 16'hDEAD;
        REQ       = '0;
        chk("tmo_race_done", 32'(DONE), 32'h4);
        chk("tmo_race_err", 32'(ERR), 32'd0);
        chk("tmo_race_rdata", 32'(RDATA), 32'h4321);
`endif

        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
